fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Round-robin write-port scheduler for synchronous_fifo. Shares one FIFO write port between
//  NUM_REQ requesters, one write per cycle. Keeps a commitment-based occupancy count so the FIFO
//  can never overflow, and flags underflow reads. Sits between requester logic and the FIFO
//  write/data inputs.
// PARAMETERS
//  NUM_REQ  4                      number of requesters (>=2)
//  DATA_W   1                      FIFO data width
//  DEPTH    8                      FIFO depth in entries
//  LVL_W    $clog2(DEPTH+1)        width of the level counter
// PORTS
//  clk           in   1               single clock; all logic on posedge
//  rst           in   1               asynchronous, active-high reset
//  req           in   NUM_REQ         per-requester write request; held until granted
//  datain_req    in   NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]; stable while req[i]
//  gnt           out  NUM_REQ         one-hot, one-cycle grant pulse
//  fifo_write    out  1               write strobe to FIFO
//  fifo_datain   out  DATA_W          data to FIFO, valid with fifo_write
//  fifo_read     in   1               FIFO read accepted this cycle (frees one entry)
//  level         out  LVL_W           committed entries (granted minus read)
//  full          out  1               level == DEPTH
//  empty         out  1               level == 0
//  err           out  1               sticky underflow flag
// BEHAVIOUR
//  - Reset (async, immediate): gnt=0, fifo_write=0, fifo_datain=0, level=0, err=0, rr_ptr=NUM_REQ-1.
//    Results: empty=1, full=0, and req[0] has first priority. An in-flight write is dropped.
//  - Eligible set: req & ~gnt (a requester is ignored in the cycle its gnt is high).
//  - Decision at edge t: if the eligible set is non-zero and level<DEPTH, pick the first eligible
//    index after rr_ptr (wrapping).
//    * From edge t: gnt[idx]=1, fifo_write=1, fifo_datain=datain_req slice idx, rr_ptr=idx.
//    * At the same edge, level increments by 1.
//    * Latency: req to gnt/fifo_write is 1 cycle.
//  - If there is no decision, gnt=0, fifo_write=0, fifo_datain holds, and rr_ptr holds.
//  - Full (level==DEPTH): no grants; requests wait. A fifo_read in the full cycle does NOT allow a
//    same-cycle grant; the first grant comes at the next edge.
//  - level update: level + grant - (fifo_read && level!=0).
//    * Simultaneous grant and read leaves level unchanged.
//    * Never wraps; saturates at 0 and DEPTH by construction.
//  - fifo_read with level==0: err=1 (sticky until rst); level stays 0.
//  - Throughput:
//    * With >=2 requesters active: 1 write/cycle.
//    * A single requester gets at most 1 grant every 2 cycles.
//  - Fairness: with all requesters asserting, grants rotate 0,1,..,NUM_REQ-1,0,...
//  - No deadlock: any held request is granted within NUM_REQ non-full decision cycles.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined:
//    * Adds output wr_count[15:0]: +1 per fifo_write, wraps 0xFFFF->0.
//    * Adds output stall_count[15:0]: +1 per cycle with a non-zero eligible set while full,
//      saturates at 0xFFFF.
//    * Both counters reset to 0.
//  FIFO_ARB_STATS_EN undefined: both ports and counters are absent; all other behaviour is
//  identical.
// STRUCTURE
//  fifo_arb_pkg:
//    * LVL_W function.
//    * Typedef of the level type.
//    * Function rr_pick(eligible, ptr), returning a one-hot grant and an index.
//  Sub-module rr_arbiter:
//    * Combinational round-robin pick from eligible and rr_ptr.
//    * Outputs a one-hot pick and a valid bit.
//    * The top module holds all registers.
// TESTING
//  1. rst mid-run with fifo_write=1 -> same cycle: fifo_write=0, gnt=0, level=0, err=0, empty=1.
//  2. req=4'b1111 from reset, no reads -> gnt sequence 0001,0010,0100,1000,0001,...
//     After 8 grants: level=8, full=1, no further gnt.
//  3. Full, then one fifo_read pulse -> level=7 at that edge; exactly one gnt on the next edge;
//     level back to 8.
//  4. level=3, grant and fifo_read in the same cycle -> level stays 3.
//  5. fifo_read at level=0 -> err=1 and stays 1 through later traffic; level=0.
//  6. Only req[2] held, datain_req[2]=1 -> gnt[2] every other cycle, fifo_datain=1.
//     With FIFO_ARB_STATS_EN, wr_count tracks the fifo_write pulses.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared sizing helpers, level type and round-robin pick function for fifo_write_arbiter
package fifo_arb_pkg;

    localparam int MAX_REQ   = 32;
    localparam int IDX_W     = 5;
    localparam int DEF_DEPTH = 8;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_LVL_W = lvl_w(DEF_DEPTH);

    typedef logic [DEF_LVL_W-1:0] level_t;

    typedef struct packed {
        logic               valid;
        logic [IDX_W-1:0]   idx;
        logic [MAX_REQ-1:0] onehot;
    } pick_t;

    // Scan starts one past ptr and wraps at n, so the last winner has lowest priority.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] eligible, input int ptr, input int n);
        pick_t              r;
        int                 i;
        logic [MAX_REQ-1:0] s;
        r = '0;
        for (int k = 1; k <= n; k++) begin
            i = ptr + k;
            if (i >= n) i = i - n;
            s = eligible >> i;
            if (!r.valid && s[0]) begin
                r.valid  = 1'b1;
                r.idx    = IDX_W'(i);
                r.onehot = MAX_REQ'(1) << i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among eligible requesters, starting after ptr
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    pick_t p;

    // Widen to the package's fixed width, pick, then narrow back to this instance's size.
    always_comb begin
        p     = rr_pick(MAX_REQ'(eligible), int'(ptr), NUM_REQ);
        pick  = NUM_REQ'(p.onehot);
        idx   = IW'(p.idx);
        valid = p.valid;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin FIFO write-port sharing with commitment-based level; optional FIFO_ARB_STATS_EN adds wr_count/stall_count
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 1,
    parameter int DEPTH   = 8,
    parameter int LVL_W   = lvl_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] datain_req,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      fifo_write,
    output logic [DATA_W-1:0]         fifo_datain,
    input  logic                      fifo_read,
    output logic [LVL_W-1:0]          level,
    output logic                      full,
    output logic                      empty,
    output logic                      err
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]               wr_count,
    output logic [15:0]               stall_count
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      idx;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick;
    logic               valid;
    logic               decide;
    logic               rd_ok;

    // A requester is masked in its grant cycle so a held req cannot win twice in a row; reads only free an entry when one exists.
    always_comb begin
        eligible = req & ~gnt;
        full     = level == LVL_W'(DEPTH);
        empty    = level == '0;
        decide   = valid && !full;
        rd_ok    = fifo_read && !empty;
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .pick     (pick),
        .idx      (idx),
        .valid    (valid)
    );

    // Grant, write strobe, data capture, pointer and level all commit on the decision edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt         <= '0;
            fifo_write  <= 1'b0;
            fifo_datain <= '0;
            level       <= '0;
            err         <= 1'b0;
            rr_ptr      <= IW'(NUM_REQ - 1);
        end else begin
            gnt        <= decide ? pick : '0;
            fifo_write <= decide;
            if (decide) begin
                fifo_datain <= datain_req[idx*DATA_W +: DATA_W];
                rr_ptr      <= idx;
            end
            level <= level + LVL_W'(decide) - LVL_W'(rd_ok);
            if (fifo_read && empty) err <= 1'b1;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Write count wraps freely; stall count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            wr_count <= wr_count + 16'(fifo_write);
            if (|eligible && full && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scoreboard bench; directed stimulus queues expected grants, a negedge monitor checks each write
module tb_fifo_write_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] datain_req = 4'b0101;
    logic       fifo_read = 1'b0;
    logic [3:0] gnt;
    logic       fifo_write;
    logic [0:0] fifo_datain;
    logic [3:0] level;
    logic       full;
    logic       empty;
    logic       err;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] wr_count;
    logic [15:0] stall_count;
`endif

    int         n_chk = 0;
    int         n_fail = 0;
    logic [4:0] exp_q[$];
    logic [4:0] e;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(1), .DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .datain_req  (datain_req),
        .gnt         (gnt),
        .fifo_write  (fifo_write),
        .fifo_datain (fifo_datain),
        .fifo_read   (fifo_read),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .err         (err)
`ifdef FIFO_ARB_STATS_EN
        ,
        .wr_count    (wr_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i);
        logic [3:0] g;
        g = 4'b0001 << i;
        exp_q.push_back({g, datain_req[i]});
    endtask

    always @(negedge clk) begin
        if (fifo_write) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: gnt=%b data=%b expected no write", gnt, fifo_datain);
            end else begin
                e = exp_q.pop_front();
                if ({gnt, fifo_datain} !== e) begin
                    n_fail++;
                    $display("FAIL write_grant: gnt/data=%b expected %b", {gnt, fifo_datain}, e);
                end
            end
        end
    end

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_write", fifo_write, 0);
        chk("rst_data", fifo_datain, 0);
`ifdef FIFO_ARB_STATS_EN
        chk("rst_wr_count", wr_count, 0);
        chk("rst_stall_count", stall_count, 0);
`endif
        req = 4'b0001;
        tick();
        chk("t1_write_before_rst", fifo_write, 1);
        rst = 1'b1;
        req = '0;
        #1;
        chk("t1_write", fifo_write, 0);
        chk("t1_gnt", gnt, 0);
        chk("t1_level", level, 0);
        chk("t1_err", err, 0);
        chk("t1_empty", empty, 1);
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 8; i++) push(i % 4);
        repeat (8) tick();
        chk("t2_level", level, 8);
        chk("t2_full", full, 1);
        chk("t2_empty", empty, 0);
        tick();
        chk("t2_no_gnt", gnt, 0);
        chk("t2_no_write", fifo_write, 0);
        chk("t2_level_hold", level, 8);
        fifo_read = 1'b1;
        tick();
        fifo_read = 1'b0;
        chk("t3_level_after_read", level, 7);
        chk("t3_no_same_cycle_gnt", gnt, 0);
        push(0);
        tick();
        chk("t3_regrant", gnt, 4'b0001);
        chk("t3_level_refull", level, 8);
        tick();
        chk("t3_no_gnt_full", gnt, 0);
        chk("t3_full", full, 1);
        req = '0;
        fifo_read = 1'b1;
        repeat (5) tick();
        chk("t4_level_drain", level, 3);
        req = 4'b0100;
        push(2);
        tick();
        chk("t4_level_grant_read", level, 3);
        chk("t4_gnt", gnt, 4'b0100);
        req = '0;
        fifo_read = 1'b0;
        tick();
        chk("t4_level_idle", level, 3);
        fifo_read = 1'b1;
        repeat (3) tick();
        chk("t5_level_zero", level, 0);
        chk("t5_err_clear", err, 0);
        chk("t5_empty", empty, 1);
        tick();
        chk("t5_err_set", err, 1);
        chk("t5_level_stays_zero", level, 0);
        fifo_read = 1'b0;
        req = 4'b0010;
        push(1);
        tick();
        req = '0;
        chk("t5_gnt", gnt, 4'b0010);
        chk("t5_level", level, 1);
        chk("t5_err_sticky", err, 1);
        tick();
        chk("t5_err_sticky2", err, 1);
        req = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push(2);
            tick();
            chk("t6_gnt_alt", gnt, (k % 2 == 0) ? 4'b0100 : 4'b0000);
        end
        req = '0;
        repeat (2) tick();
        chk("t6_level", level, 4);
        chk("t6_data", fifo_datain, 1);
`ifdef FIFO_ARB_STATS_EN
        chk("stats_wr_count", wr_count, 14);
        chk("stats_stall_count", stall_count, 3);
`endif
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
